// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// The operand is cut into STAGES equal slices; slice k is resolved in registered stage k
// using GROUP-bit lookahead cells chained by a group-level carry.
// Optional build macro: CLA_PIPE_SAT_EN clamps overflowing results to the signed limits.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / GROUP;
    localparam int MID   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST  = STAGES - 1;

    // One slice of lookahead: per-cell g/p, group carry c_{i+1} = G_i | P_i & c_i,
    // and bit carries inside each cell derived from that cell's carry-in.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             cin);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] c;
        logic             gg;
        logic             gp;
        logic             cg;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        cg = cin;
        for (int i = 0; i < NGRP; i++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gg = g[i*GROUP+j] | (p[i*GROUP+j] & gg);
                gp = gp & p[i*GROUP+j];
            end
            c[i*GROUP] = cg;
            for (int j = 0; j < GROUP - 1; j++) begin
                c[i*GROUP+j+1] = g[i*GROUP+j] | (p[i*GROUP+j] & c[i*GROUP+j]);
            end
            cg = gg | (gp & cg);
        end
        return {cg, p ^ c};
    endfunction

    // Drop a freshly computed slice into the travelling partial sum.
    function automatic logic [WIDTH-1:0] place_slice(input logic [WIDTH-1:0] base,
                                                     input logic [SLICE-1:0] s,
                                                     input int               k);
        logic [WIDTH-1:0] r;
        r = base;
        r[k*SLICE +: SLICE] = s;
        return r;
    endfunction

`ifdef CLA_PIPE_SAT_EN
    // Clamp to the signed limit in the direction of the overflow.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ov,
                                                  input logic             a_neg);
        logic signed [WIDTH-1:0] lim;
        lim = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return ov ? lim : raw;
    endfunction
`endif

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Per-stage combinational view: what enters stage k and what it produces.
    logic [WIDTH-1:0] st_a  [STAGES];
    logic [WIDTH-1:0] st_b  [STAGES];
    logic [WIDTH-1:0] st_s  [STAGES];
    logic [WIDTH-1:0] st_r  [STAGES];
    logic             st_ci [STAGES];
    logic             st_co [STAGES];
    logic             st_v  [STAGES];

    // Inter-stage registers (between slice stages; the last stage feeds the outputs).
    logic [WIDTH-1:0] a_p   [MID];
    logic [WIDTH-1:0] b_p   [MID];
    logic [WIDTH-1:0] s_p   [MID];
    logic             c_p   [MID];
    logic             vld_p [MID];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [SLICE:0] res;
            if (k == 0) begin : g_src
                // ---- stage 0: operand prep (subtract = add inverted B with carry-in 1)
                assign st_a[k]  = a;
                assign st_b[k]  = sub ? ~b : b;
                assign st_ci[k] = sub | c_in;
                assign st_s[k]  = '0;
                assign st_v[k]  = in_valid;
            end else begin : g_src
                // ---- stage k: consume registers of stage k-1
                assign st_a[k]  = a_p[k-1];
                assign st_b[k]  = b_p[k-1];
                assign st_ci[k] = c_p[k-1];
                assign st_s[k]  = s_p[k-1];
                assign st_v[k]  = vld_p[k-1];
            end
            assign res      = cla_slice(st_a[k][k*SLICE +: SLICE], st_b[k][k*SLICE +: SLICE], st_ci[k]);
            assign st_co[k] = res[SLICE];
            assign st_r[k]  = place_slice(st_s[k], res[SLICE-1:0], k);
        end
    endgenerate

    // Stage valid bits shift on advance and clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MID; k++) vld_p[k] <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES - 1; k++) vld_p[k] <= st_v[k];
        end
    end

    // Stage data registers load only for real beats; bubbles leave them untouched.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) begin
            if (advance && st_v[k]) begin
                a_p[k] <= st_a[k];
                b_p[k] <= st_b[k];
                s_p[k] <= st_r[k];
                c_p[k] <= st_co[k];
            end
        end
    end

    // ---- last stage: flags from the carried operand MSBs and the completed sum
    logic [WIDTH-1:0] fin_raw;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_ovf;
    assign fin_raw = st_r[LAST];
    assign fin_ovf = (st_a[LAST][WIDTH-1] == st_b[LAST][WIDTH-1]) &&
                     (fin_raw[WIDTH-1] != st_a[LAST][WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
    assign fin_sum = saturate(fin_raw, fin_ovf, st_a[LAST][WIDTH-1]);
`else
    assign fin_sum = fin_raw;
`endif

    // Output register: cleared by reset so the result port reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= st_v[LAST];
            if (st_v[LAST]) begin
                sum   <= fin_sum;
                c_out <= st_co[LAST];
                ovf   <= fin_ovf;
                zero  <= ~|fin_sum;
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: the driver pushes expected results on acceptance,
// an independent monitor pops and compares whenever a result beat is consumed.
module tb_cla_pipe_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int GROUP  = 4;
`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam longint MAXS = (longint'(1) << (WIDTH - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
        logic             zero;
        int               cyc;
        bit               exact;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: true signed / unsigned arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s, input logic ci);
        exp_t e;
        longint sx, sy, r;
        longint unsigned ux, uy, ur;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r       = sx - sy;
            ur      = ux - uy;
            e.c_out = (ux >= uy);
        end else begin
            r       = sx + sy + longint'(ci);
            ur      = ux + uy + longint'(ci);
            e.c_out = ((ur >> WIDTH) != 0);
        end
        e.sum = ur[WIDTH-1:0];
        e.ovf = (r > MAXS) || (r < MINS);
        if (SAT && e.ovf) e.sum = (r > MAXS) ? WIDTH'(MAXS) : WIDTH'(MINS);
        e.zero  = (e.sum == '0);
        e.cyc   = 0;
        e.exact = 1'b0;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            4:       v = WIDTH'(1);
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    // One cycle of stimulus; pushes the expectation if the beat is accepted.
    task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic s, input logic ci, input logic ordy,
                         input exp_t e, input bit exact, output bit acc);
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        sub       = s;
        c_in      = ci;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.cyc   = cyc;
            e.exact = exact;
            sb_q.push_back(e);
        end
    endtask

    task automatic send_rand(input logic v, input logic ordy, input bit exact, output bit acc);
        logic [WIDTH-1:0] x, y;
        logic s, ci;
        x  = pick();
        y  = pick();
        s  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        drive(v, x, y, s, ci, ordy, model(x, y, s, ci), exact, acc);
    endtask

    task automatic send_dir(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic s, input logic ci, input logic [WIDTH-1:0] es,
                            input logic ec, input logic eo, input logic ez);
        exp_t e;
        bit   acc;
        int   n;
        e.sum = es; e.c_out = ec; e.ovf = eo; e.zero = ez; e.cyc = 0; e.exact = 1'b1;
        n = 0;
        do begin
            drive(1'b1, x, y, s, ci, 1'b1, e, 1'b1, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_%s in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic drain();
        exp_t e;
        bit   acc;
        int   n;
        e = model('0, '0, 1'b0, 1'b0);
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
            n++;
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e, 1'b0, acc);
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d required 0", sb_q.size());
        end
    endtask

    // Monitor: compares every consumed beat, latency, and stability while stalled.
    initial begin : monitor
        exp_t             e;
        bit               held;
        logic [WIDTH-1:0] h_sum;
        logic             h_c, h_o, h_z;
        int               lat;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checks++;
                    if (out_valid !== 1'b1 || sum !== h_sum || c_out !== h_c || ovf !== h_o || zero !== h_z) begin
                        errors++;
                        $display("FAIL hold_stable got v=%b sum=%h c=%b o=%b z=%b required v=1 sum=%h c=%b o=%b z=%b",
                                 out_valid, sum, c_out, ovf, zero, h_sum, h_c, h_o, h_z);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got sum=%h required no beat", sum);
                    end else begin
                        e = sb_q.pop_front();
                        if (sum !== e.sum || c_out !== e.c_out || ovf !== e.ovf || zero !== e.zero) begin
                            errors++;
                            $display("FAIL result got sum=%h c=%b o=%b z=%b required sum=%h c=%b o=%b z=%b",
                                     sum, c_out, ovf, zero, e.sum, e.c_out, e.ovf, e.zero);
                        end
                        checks++;
                        lat = cyc - e.cyc;
                        if (e.exact ? (lat != STAGES) : (lat < STAGES)) begin
                            errors++;
                            $display("FAIL latency got %0d required %0d", lat, STAGES);
                        end
                    end
                end
                held  = out_valid && !out_ready;
                h_sum = sum; h_c = c_out; h_o = ovf; h_z = zero;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit acc;
        logic [WIDTH-1:0] x, y;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b sum=%h c=%b o=%b z=%b required all 0",
                     out_valid, sum, c_out, ovf, zero);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end

        // Directed vectors, back to back with out_ready held high.
        send_dir("add",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        send_dir("slice_cy", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send_dir("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send_dir("cin",      32'hFFFF_FFFE, 32'h0000_0000, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send_dir("sub_brw",  32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send_dir("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send_dir("neg_ovf",  32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                 SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1, SAT ? 1'b0 : 1'b1);
        send_dir("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0,
                 SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        drain();

        // Backpressure: two beats enter, output stalls, third beat must wait.
        send_rand(1'b1, 1'b1, 1'b0, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL bp_beat1 accepted=%b required 1", acc); end
        send_rand(1'b1, 1'b0, 1'b0, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL bp_beat2 accepted=%b required 1", acc); end
        x = pick();
        y = pick();
        e = model(x, y, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, x, y, 1'b0, 1'b1, 1'b0, e, 1'b0, acc);
            checks++;
            if (in_ready !== 1'b0 || acc) begin
                errors++;
                $display("FAIL bp_in_ready got %b required 0", in_ready);
            end
        end
        drive(1'b1, x, y, 1'b0, 1'b1, 1'b1, e, 1'b0, acc);
        checks++;
        if (!acc) begin errors++; $display("FAIL bp_beat3 accepted=%b required 1", acc); end
        send_rand(1'b1, 1'b1, 1'b0, acc);
        drain();

        // Reset while a beat is in flight: it must never emerge.
        send_rand(1'b1, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflight got v=%b sum=%h required v=0 sum=0", out_valid, sum);
        end
        for (int i = 0; i < 4; i++) send_rand(1'b0, 1'b1, 1'b0, acc);
        send_dir("post_rst", 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1235, 1'b0, 1'b0, 1'b0);
        drain();

        // Random stream with no stalls: latency must be exact.
        for (int i = 0; i < 400; i++) send_rand(1'($urandom_range(0, 3) != 0), 1'b1, 1'b1, acc);
        drain();

        // Random stream with random backpressure.
        for (int i = 0; i < 3000; i++)
            send_rand(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'b0, acc);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; the next-generation ALU add path replacing fixed-width 4-bit CLA cells.
- Operand width split into STAGES equal slices; each slice is resolved in one registered stage using GROUP-bit lookahead cells with generate/propagate combining.
- Valid/ready handshake on both sides so the ALU can be stalled.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES*GROUP.
- STAGES, 2, pipeline depth = latency in cycles; 1..WIDTH/GROUP.
- GROUP, 4, bits per lookahead cell inside a slice; 2 or 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  pipeline accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- c_in  input  1  carry-in for add; ignored when sub=1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high, on clk and rst.
- While rst=1, all stage valid bits clear, and out_valid, sum, c_out, ovf and zero are all 0 at the next edge.
- A mid-flight operation is discarded on reset, with no partial result emitted.
- advance = !out_valid | out_ready; in_ready = advance. in_ready is combinational, with no dependence on in_valid.
- A beat is accepted on an edge where in_valid & in_ready.
- On advance, every stage register shifts one position. Stage k valid takes stage k-1 valid; stage 0 valid takes in_valid.
- On !advance, all stages hold (global stall). sum/flags remain stable while out_valid & !out_ready.
- Latency is exactly STAGES cycles from acceptance to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Operand prep in stage 0: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in.
- Stage k adds slice k (bits [(k+1)*W/S-1 : k*W/S]) using the carry registered from stage k-1.
  - Upper operand slices travel unmodified in the pipeline.
  - Already-computed low sum slices travel forward.
- Within a slice, GROUP-bit cells produce g/p; a group level combines them: c_{i+1} = g_i | p_i & c_i.
- Only the carry out of the last slice becomes c_out.
- ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb), computed in the last stage. The stage-0 operand MSBs are carried forward for this.
- zero = ~|sum, over the final (post-saturation, if enabled) sum.
- Bubble stages keep their data registers unchanged (their valid is 0). Outputs are meaningful only when out_valid=1.
- Wrap-around: results are modulo 2^WIDTH; e.g. 0xFFFFFFFF+1 gives 0 with c_out=1 and zero=1.
- STAGES=1: the adder is fully combinational into a single output register (latency 1).

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- When defined:
  - When ovf=1, sum is clamped in the final stage: positive overflow → 0x7FF..F, negative → 0x800..0.
  - ovf still reports 1.
  - zero is evaluated on the clamped value (never 1 on saturation).
- When undefined: sum is always the raw wrapped result. No clamp logic is present.

Test Plan (WIDTH=32, STAGES=2, GROUP=4 unless noted):
- Basic add: a=0x0000_0005, b=0x0000_0003, sub=0, c_in=0, out_ready=1 → two cycles later out_valid=1, sum=0x8, c_out=0, ovf=0, zero=0.
- Carry ripple across slice boundary: a=0x0000_FFFF, b=0x1, c_in=0 → sum=0x0001_0000. Then a=0xFFFF_FFFF, b=0x1 → sum=0, c_out=1, zero=1.
- Subtract/overflow: a=0x0000_0000, b=0x1, sub=1, c_in=1 (ignored) → sum=0xFFFF_FFFF, c_out=0. Then a=0x7FFF_FFFF, b=0x1, add → sum=0x8000_0000, ovf=1 (with CLA_PIPE_SAT_EN: sum=0x7FFF_FFFF, ovf=1).
- Backpressure: stream 4 beats back-to-back with out_ready=0 from cycle 2 → in_ready falls once the output is occupied. The held result stays stable, no beat is lost or duplicated, and in-order results appear after out_ready=1.
- Reset mid-operation: accept beat, assert rst for 1 cycle before it emerges → out_valid=0 after the reset edge, and the dropped beat never appears. A new beat after reset completes with latency 2.
- Sweep: STAGES=1,2,4,8 and GROUP=2,4 with 10k random operands/handshakes against a reference adder model → bit-exact sum/c_out/ovf/zero and latency=STAGES.
